// File: rtl/trap_sequencer.sv
// Trap controller: prioritises faults, squashes the faulting instruction, then sequences
// ucause/uepc, utval and the utvec redirect. Optional trap counter under TRAP_COUNT_EN.
module trap_sequencer #(
  parameter int unsigned CAUSE_W        = 32,
  parameter logic [2:0]  TVAL_SEL_PC    = 3'b001,
  parameter logic [2:0]  TVAL_SEL_INSTR = 3'b010,
  parameter int unsigned CNT_W          = 16
) (
`ifdef TRAP_COUNT_EN
  output logic [CNT_W-1:0]   oTrapCount,
`endif
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iPcMisaligned,
  input  logic               iOutText,
  input  logic               iIllegal,
  input  logic               iEcall,
  input  logic               iMemRead,
  input  logic               iMemWrite,
  input  logic               iExceptionLoad,
  input  logic               iExceptionStore,
  input  logic               iOutData,
  input  logic               iDecCSRWrite,
  input  logic               iDecSelNumRegCSR,
  input  logic [2:0]         iDecOrigWDataCSR,
  output logic               oSquash,
  output logic               oStall,
  output logic               oCSRWrite,
  output logic               oSelNumRegCSR,
  output logic [2:0]         oOrigWDataCSR,
  output logic               oPcOrUtvec,
  output logic [CAUSE_W-1:0] oUcause,
  output logic               oCauseValid,
  output logic               oBusy
);

  typedef enum logic [1:0] {StIdle, StCause, StTval, StRedirect} trapStateT;

  trapStateT  state;
  logic [3:0] latchedCause;
  logic [2:0] latchedSel;

  logic       trapHit;
  logic [3:0] trapCause;
  logic [2:0] trapSel;

  always_comb begin
    trapHit   = 1'b1;
    trapCause = 4'd0;
    if (iPcMisaligned)                       trapCause = 4'd0;
    else if (iOutText)                       trapCause = 4'd1;
    else if (iIllegal)                       trapCause = 4'd2;
    else if (iEcall)                         trapCause = 4'd8;
    else if (iMemRead && iExceptionLoad)     trapCause = 4'd4;
    else if (iMemRead && iOutData)           trapCause = 4'd5;
    else if (iMemWrite && iExceptionStore)   trapCause = 4'd6;
    else if (iMemWrite && iOutData)          trapCause = 4'd7;
    else                                     trapHit   = 1'b0;
    trapSel = (trapCause == 4'd1 || trapCause == 4'd2) ? TVAL_SEL_INSTR : TVAL_SEL_PC;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state        <= StIdle;
      latchedCause <= 4'd0;
      latchedSel   <= 3'd0;
    end else begin
      unique case (state)
        StIdle: begin
          if (trapHit) begin
            state        <= StCause;
            latchedCause <= trapCause;
            latchedSel   <= trapSel;
          end
        end
        StCause:    state <= StTval;
        StTval:     state <= StRedirect;
        StRedirect: state <= StIdle;
        default:    state <= StIdle;
      endcase
    end
  end

  // While reset is asserted the sequence is treated as already aborted: only pass-through.
  always_comb begin
    oSquash       = 1'b0;
    oStall        = 1'b0;
    oCSRWrite     = 1'b0;
    oSelNumRegCSR = 1'b0;
    oOrigWDataCSR = 3'd0;
    oPcOrUtvec    = 1'b0;
    oUcause       = '0;
    oCauseValid   = 1'b0;
    oBusy         = 1'b0;
    if (iRST || state == StIdle) begin
      oCSRWrite     = iDecCSRWrite;
      oSelNumRegCSR = iDecSelNumRegCSR;
      oOrigWDataCSR = iDecOrigWDataCSR;
      oSquash       = trapHit && !iRST;
      oStall        = trapHit && !iRST;
    end else begin
      oBusy   = 1'b1;
      oUcause = CAUSE_W'(latchedCause);
      unique case (state)
        StCause: begin
          oSquash     = 1'b1;
          oStall      = 1'b1;
          oCauseValid = 1'b1;
        end
        StTval: begin
          oSquash       = 1'b1;
          oStall        = 1'b1;
          oCSRWrite     = 1'b1;
          oSelNumRegCSR = 1'b1;
          oOrigWDataCSR = latchedSel;
        end
        StRedirect: begin
          oSquash    = 1'b1;
          oPcOrUtvec = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef TRAP_COUNT_EN
  logic [CNT_W-1:0] trapCount;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      trapCount <= '0;
    end else if (state == StRedirect && trapCount != {CNT_W{1'b1}}) begin
      trapCount <= trapCount + 1'b1;
    end
  end

  assign oTrapCount = trapCount;
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer; counter checks built only with TRAP_COUNT_EN.
module tb_trap_sequencer;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iPcMisaligned, iOutText, iIllegal, iEcall, iMemRead, iMemWrite;
  logic        iExceptionLoad, iExceptionStore, iOutData;
  logic        iDecCSRWrite, iDecSelNumRegCSR;
  logic [2:0]  iDecOrigWDataCSR;
  logic        oSquash, oStall, oCSRWrite, oSelNumRegCSR, oPcOrUtvec, oCauseValid, oBusy;
  logic [2:0]  oOrigWDataCSR;
  logic [31:0] oUcause;
`ifdef TRAP_COUNT_EN
  logic [15:0] oTrapCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 iCLK = ~iCLK;

  trap_sequencer dut (
`ifdef TRAP_COUNT_EN
    .oTrapCount       (oTrapCount),
`endif
    .iCLK             (iCLK),
    .iRST             (iRST),
    .iPcMisaligned    (iPcMisaligned),
    .iOutText         (iOutText),
    .iIllegal         (iIllegal),
    .iEcall           (iEcall),
    .iMemRead         (iMemRead),
    .iMemWrite        (iMemWrite),
    .iExceptionLoad   (iExceptionLoad),
    .iExceptionStore  (iExceptionStore),
    .iOutData         (iOutData),
    .iDecCSRWrite     (iDecCSRWrite),
    .iDecSelNumRegCSR (iDecSelNumRegCSR),
    .iDecOrigWDataCSR (iDecOrigWDataCSR),
    .oSquash          (oSquash),
    .oStall           (oStall),
    .oCSRWrite        (oCSRWrite),
    .oSelNumRegCSR    (oSelNumRegCSR),
    .oOrigWDataCSR    (oOrigWDataCSR),
    .oPcOrUtvec       (oPcOrUtvec),
    .oUcause          (oUcause),
    .oCauseValid      (oCauseValid),
    .oBusy            (oBusy)
  );

  task automatic clearIn();
    iPcMisaligned = 0; iOutText = 0; iIllegal = 0; iEcall = 0; iMemRead = 0; iMemWrite = 0;
    iExceptionLoad = 0; iExceptionStore = 0; iOutData = 0;
    iDecCSRWrite = 0; iDecSelNumRegCSR = 0; iDecOrigWDataCSR = 3'd0;
  endtask

  // Advance one clock; outputs are then sampled well clear of the edge.
  task automatic tick();
    @(posedge iCLK);
    #2;
  endtask

  task automatic test_reset();
    clearIn();
    iRST = 1; iDecCSRWrite = 1; iDecSelNumRegCSR = 1; iDecOrigWDataCSR = 3'b101;
    tick();
    tick();
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", oBusy); end
    checks++; if (oSquash !== 1'b0 || oStall !== 1'b0) begin errors++;
      $display("FAIL reset_squash_stall got %b%b exp 00", oSquash, oStall); end
    checks++; if (oUcause !== 32'd0 || oCauseValid !== 1'b0 || oPcOrUtvec !== 1'b0) begin errors++;
      $display("FAIL reset_zero got ucause=%0d cv=%b pc=%b exp 0 0 0", oUcause, oCauseValid, oPcOrUtvec); end
    checks++; if ({oCSRWrite, oSelNumRegCSR, oOrigWDataCSR} !== 5'b11101) begin errors++;
      $display("FAIL reset_passthru got %b exp 11101", {oCSRWrite, oSelNumRegCSR, oOrigWDataCSR}); end
    iRST = 0;
    clearIn();
    tick();
  endtask

  task automatic test_ecall();
    clearIn();
    iEcall = 1;
    #1;
    checks++; if (oSquash !== 1'b1 || oStall !== 1'b1 || oBusy !== 1'b0) begin errors++;
      $display("FAIL ecall_c0 got sq=%b st=%b busy=%b exp 1 1 0", oSquash, oStall, oBusy); end
    tick();
    iEcall = 0; iDecCSRWrite = 1; iDecOrigWDataCSR = 3'b111;
    #1;
    checks++; if (oUcause !== 32'd8 || oCauseValid !== 1'b1) begin errors++;
      $display("FAIL ecall_c1_cause got %0d cv=%b exp 8 1", oUcause, oCauseValid); end
    checks++; if (oCSRWrite !== 1'b0 || oOrigWDataCSR !== 3'd0 || oStall !== 1'b1) begin errors++;
      $display("FAIL ecall_c1_ctrl got wr=%b sel=%b st=%b exp 0 000 1", oCSRWrite, oOrigWDataCSR, oStall); end
    tick();
    checks++; if ({oCSRWrite, oSelNumRegCSR, oOrigWDataCSR} !== 5'b11001) begin errors++;
      $display("FAIL ecall_c2_tval got %b exp 11001", {oCSRWrite, oSelNumRegCSR, oOrigWDataCSR}); end
    checks++; if (oUcause !== 32'd8 || oCauseValid !== 1'b0 || oStall !== 1'b1) begin errors++;
      $display("FAIL ecall_c2_hold got %0d cv=%b st=%b exp 8 0 1", oUcause, oCauseValid, oStall); end
    tick();
    checks++; if (oPcOrUtvec !== 1'b1 || oStall !== 1'b0 || oSquash !== 1'b1 || oCSRWrite !== 1'b0) begin
      errors++; $display("FAIL ecall_c3_redirect got pc=%b st=%b sq=%b wr=%b exp 1 0 1 0",
                         oPcOrUtvec, oStall, oSquash, oCSRWrite); end
    tick();
    checks++; if (oBusy !== 1'b0 || oSquash !== 1'b0 || oCSRWrite !== 1'b1 || oPcOrUtvec !== 1'b0) begin
      errors++; $display("FAIL ecall_c4_idle got busy=%b sq=%b wr=%b pc=%b exp 0 0 1 0",
                         oBusy, oSquash, oCSRWrite, oPcOrUtvec); end
    clearIn();
  endtask

  task automatic test_illegal();
    clearIn();
    iIllegal = 1;
    tick();
    clearIn();
    checks++; if (oUcause !== 32'd2) begin errors++; $display("FAIL illegal_cause got %0d exp 2", oUcause); end
    tick();
    checks++; if (oOrigWDataCSR !== 3'b010) begin errors++;
      $display("FAIL illegal_tval_sel got %b exp 010", oOrigWDataCSR); end
    tick();
    tick();
  endtask

  task automatic test_priority();
    clearIn();
    iPcMisaligned = 1; iIllegal = 1; iMemRead = 1; iExceptionLoad = 1;
    tick();
    clearIn();
    checks++; if (oUcause !== 32'd0 || oCauseValid !== 1'b1) begin errors++;
      $display("FAIL priority_cause got %0d cv=%b exp 0 1", oUcause, oCauseValid); end
    tick();
    checks++; if (oOrigWDataCSR !== 3'b001) begin errors++;
      $display("FAIL priority_tval_sel got %b exp 001", oOrigWDataCSR); end
    tick();
    tick();
    // Lower-priority pair: store misaligned beats store out-of-range.
    iMemWrite = 1; iExceptionStore = 1; iOutData = 1;
    tick();
    clearIn();
    checks++; if (oUcause !== 32'd6) begin errors++; $display("FAIL priority_store got %0d exp 6", oUcause); end
    tick(); tick(); tick();
  endtask

  task automatic test_gating();
    clearIn();
    iOutData = 1; iExceptionLoad = 1; iExceptionStore = 1;
    iDecCSRWrite = 1; iDecSelNumRegCSR = 1; iDecOrigWDataCSR = 3'b100;
    #1;
    checks++; if (oSquash !== 1'b0 || oStall !== 1'b0) begin errors++;
      $display("FAIL gating_squash got %b%b exp 00", oSquash, oStall); end
    checks++; if ({oCSRWrite, oSelNumRegCSR, oOrigWDataCSR} !== 5'b11100) begin errors++;
      $display("FAIL gating_passthru got %b exp 11100", {oCSRWrite, oSelNumRegCSR, oOrigWDataCSR}); end
    tick();
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL gating_busy got %b exp 0", oBusy); end
    clearIn();
  endtask

  task automatic test_reset_mid_tval();
    clearIn();
    iMemRead = 1; iExceptionLoad = 1;
    tick();
    clearIn();
    checks++; if (oUcause !== 32'd4) begin errors++; $display("FAIL rst_load_cause got %0d exp 4", oUcause); end
    tick();
    checks++; if (oCSRWrite !== 1'b1) begin errors++; $display("FAIL rst_in_tval got %b exp 1", oCSRWrite); end
    iRST = 1;
    tick();
    iRST = 0;
    #1;
    checks++; if (oBusy !== 1'b0 || oCSRWrite !== 1'b0 || oPcOrUtvec !== 1'b0 || oSquash !== 1'b0) begin
      errors++; $display("FAIL rst_mid_tval got busy=%b wr=%b pc=%b sq=%b exp 0 0 0 0",
                         oBusy, oCSRWrite, oPcOrUtvec, oSquash); end
    tick();
    checks++; if (oBusy !== 1'b0 || oUcause !== 32'd0) begin errors++;
      $display("FAIL rst_mid_tval_after got busy=%b ucause=%0d exp 0 0", oBusy, oUcause); end
  endtask

  task automatic test_ignored_and_counter();
    clearIn();
    iMemWrite = 1; iOutData = 1;
    #1;
    checks++; if (oSquash !== 1'b1) begin errors++; $display("FAIL store_squash got %b exp 1", oSquash); end
    tick();
    clearIn();
    iIllegal = 1;
    #1;
    checks++; if (oUcause !== 32'd7) begin errors++; $display("FAIL ignored_cause got %0d exp 7", oUcause); end
    tick();
    iIllegal = 0;
    checks++; if (oUcause !== 32'd7 || oOrigWDataCSR !== 3'b001) begin errors++;
      $display("FAIL ignored_tval got %0d sel=%b exp 7 001", oUcause, oOrigWDataCSR); end
    tick();
`ifdef TRAP_COUNT_EN
    checks++; if (oTrapCount !== 16'd0) begin errors++;
      $display("FAIL count_before got %0d exp 0", oTrapCount); end
`endif
    tick();
    checks++; if (oBusy !== 1'b0 || oSquash !== 1'b0) begin errors++;
      $display("FAIL ignored_no_reentry got busy=%b sq=%b exp 0 0", oBusy, oSquash); end
`ifdef TRAP_COUNT_EN
    checks++; if (oTrapCount !== 16'd1) begin errors++;
      $display("FAIL count_after got %0d exp 1", oTrapCount); end
    force dut.trapCount = 16'hFFFE;
    #1;
    release dut.trapCount;
    for (int t = 0; t < 2; t++) begin
      iEcall = 1;
      tick();
      iEcall = 0;
      tick(); tick(); tick();
      checks++; if (oTrapCount !== 16'hFFFF) begin errors++;
        $display("FAIL count_sat%0d got %h exp ffff", t, oTrapCount); end
    end
`endif
  endtask

  task automatic test_back_to_back();
    clearIn();
    iPcMisaligned = 1;
    tick(); tick(); tick(); tick();
    // Fault still present at the handler: immediate re-entry from IDLE.
    checks++; if (oBusy !== 1'b0 || oSquash !== 1'b1 || oStall !== 1'b1) begin errors++;
      $display("FAIL b2b_reentry got busy=%b sq=%b st=%b exp 0 1 1", oBusy, oSquash, oStall); end
    tick();
    clearIn();
    checks++; if (oBusy !== 1'b1 || oCauseValid !== 1'b1 || oUcause !== 32'd0) begin errors++;
      $display("FAIL b2b_cause got busy=%b cv=%b ucause=%0d exp 1 1 0", oBusy, oCauseValid, oUcause); end
    tick(); tick(); tick();
  endtask

  initial begin
    clearIn();
    iRST = 1;
    test_reset();
    test_ecall();
    test_illegal();
    test_priority();
    test_gating();
    test_reset_mid_tval();
    test_ignored_and_counter();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Exception/trap controller for the single-cycle RV32 core. It sits between the datapath's exception flags and the datapath's CSR/PC control inputs.
- It detects and prioritises faults in the current instruction and squashes that instruction's commit.
- It then sequences the CSR writes (ucause/uepc/utval) over multiple cycles while freezing the PC, and finally redirects the PC to utvec.
- It drives wCUcause, wCCSRWrite, wCSelectNumRegCSR, wCOrigWriteDataCSR and wCPcOrUtvec, overriding the main decoder while active.

Parameters:
- CAUSE_W, 32, width of oUcause.
- TVAL_SEL_PC, 3'b001, CSR write-data mux code selecting the PC.
- TVAL_SEL_INSTR, 3'b010, CSR write-data mux code selecting the instruction word.
- CNT_W, 16, width of the trap counter (optional feature only).

Ports:
- iCLK  in  1  core clock.
- iRST  in  1  reset, synchronous, active-high.
- iPcMisaligned  in  1  PC[1:0]!=0.
- iOutText  in  1  fetch address outside the text segment.
- iIllegal  in  1  decoder: illegal opcode.
- iEcall  in  1  decoder: ecall.
- iMemRead  in  1  current instruction is a load.
- iMemWrite  in  1  current instruction is a store.
- iExceptionLoad  in  1  load misaligned.
- iExceptionStore  in  1  store misaligned.
- iOutData  in  1  data address outside the data segment.
- iDecCSRWrite  in  1  decoder CSR write request (pass-through).
- iDecSelNumRegCSR  in  1  decoder CSR number select (pass-through).
- iDecOrigWDataCSR  in  3  decoder CSR data select (pass-through).
- oSquash  out  1  block RegWrite/MemWrite/FRegWrite of the current instruction.
- oStall  out  1  hold the PC.
- oCSRWrite  out  1  to wCCSRWrite.
- oSelNumRegCSR  out  1  to wCSelectNumRegCSR.
- oOrigWDataCSR  out  3  to wCOrigWriteDataCSR.
- oPcOrUtvec  out  1  to wCPcOrUtvec.
- oUcause  out  CAUSE_W  to wCUcause.
- oCauseValid  out  1  ucause/uepc capture strobe.
- oBusy  out  1  state!=IDLE.

Behaviour:
- Reset (iRST high at posedge): state=IDLE, latched cause=0, latched tval select=0.
  - All outputs are 0 except the pass-through outputs, which follow the decoder.
  - Reset overrides any sequence in progress. No partial CSR write is issued after reset.
- Detection is combinational, evaluated only in IDLE. Priority, highest first, with the cause code:
  1. iPcMisaligned: 0
  2. iOutText: 1
  3. iIllegal: 2
  4. iEcall: 8
  5. iMemRead&iExceptionLoad: 4
  6. iMemRead&iOutData: 5
  7. iMemWrite&iExceptionStore: 6
  8. iMemWrite&iOutData: 7
- iOutData and the misaligned flags are ignored when neither iMemRead nor iMemWrite is set.
- tval select:
  - Causes 1 and 2 select TVAL_SEL_INSTR.
  - All other causes select TVAL_SEL_PC.
- States:
  - IDLE:
    - Pass-through of the decoder CSR signals.
    - oPcOrUtvec=0.
    - When an exception is detected: oSquash=1 and oStall=1 in the same cycle; the cause and tval select are latched; next state is CAUSE.
  - CAUSE (1 cycle):
    - oSquash=1, oStall=1.
    - oUcause=latched cause, oCauseValid=1.
    - oCSRWrite=0.
    - Next state: TVAL.
  - TVAL (1 cycle):
    - oSquash=1, oStall=1.
    - oCSRWrite=1, oSelNumRegCSR=1 (utval).
    - oOrigWDataCSR=latched select, oUcause held.
    - Next state: REDIRECT.
  - REDIRECT (1 cycle):
    - oSquash=1, oStall=0.
    - oPcOrUtvec=1, so the PC loads utvec at the next edge.
    - Next state: IDLE.
- Latency from detection to the PC holding utvec: 4 edges. The PC is constant during IDLE-detect, CAUSE and TVAL, so uepc and utval see the faulting PC.
- Outside IDLE:
  - The decoder CSR inputs are ignored.
  - New exception flags are ignored; only the first latched cause is reported.
- A fault at the handler address re-enters the sequence from IDLE on the following cycle. There is no lockout.
- oUcause=0 and oCauseValid=0 in IDLE.

Optional Feature:
- Macro: TRAP_COUNT_EN.
- Defined:
  - Adds output oTrapCount[CNT_W-1:0].
  - The count increments by 1 on each REDIRECT→IDLE transition and saturates at all-ones.
  - It is cleared by reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset mid-TVAL.
  - Stimulus: load fault; iRST asserted in the TVAL cycle.
  - Required response: next cycle state IDLE; oCSRWrite=0, oPcOrUtvec=0, oSquash=0.
- Ecall.
  - Stimulus: iEcall=1 for 1 cycle in IDLE.
  - Required response:
    - Cycle 0: oSquash=1, oStall=1.
    - Cycle 1: oUcause=8, oCauseValid=1.
    - Cycle 2: oCSRWrite=1, oSelNumRegCSR=1, oOrigWDataCSR=3'b001.
    - Cycle 3: oPcOrUtvec=1, oStall=0.
    - Cycle 4: oBusy=0.
- Illegal instruction.
  - Stimulus: iIllegal=1.
  - Required response: oUcause=2; oOrigWDataCSR=3'b010 in TVAL.
- Priority.
  - Stimulus: iPcMisaligned=1, iIllegal=1, iMemRead=1, iExceptionLoad=1 together.
  - Required response: oUcause=0.
- Gating.
  - Stimulus: iOutData=1 with iMemRead=0, iMemWrite=0.
  - Required response: no trap; oSquash=0; pass-through of iDecCSRWrite=1, iDecOrigWDataCSR=3'b100.
- Ignored exception and counter.
  - Stimulus: store fault (iMemWrite=1, iOutData=1); iIllegal pulsed during CAUSE.
  - Required response: oUcause stays 7. With TRAP_COUNT_EN, oTrapCount goes 0→1 after REDIRECT, and saturates at 16'hFFFF after forced preload.
